pll_option_sequencer: RTL

//  Upstream feeder of the PLL clock generator's 3-bit pll_option input.

---
 rtl/pll_option_sequencer_pkg.sv | 21 ++
 rtl/pll_option_sequencer_if.sv | 30 +++
 rtl/pll_option_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/pll_option_sequencer_pkg.sv
// Shared types and constants for the PLL clock-option sequencer: FSM encoding,
// default register address, read-data bit layout and the hotkey wrap helper.
package pll_option_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StApply   = 2'd1,
        StHoldoff = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_REG_ADDR = 8'hB0;
    localparam int unsigned OPT_W         = 3;
    localparam int unsigned DOUT_BUSY_BIT = 7;
    localparam int unsigned DOUT_PEND_BIT = 6;

    function automatic logic [OPT_W-1:0] next_option(input logic [OPT_W-1:0] base,
                                                     input logic [OPT_W-1:0] max_opt);
        return (base == max_opt) ? '0 : base + 1'b1;
    endfunction

endpackage

// File: rtl/pll_option_sequencer_if.sv
// ZXUNO register-bus slice seen by the option sequencer: address, strobes,
// write data and the read-data/output-enable pair.
interface pll_option_sequencer_if;

    logic [7:0] zxuno_addr;
    logic       zxuno_regwr;
    logic       zxuno_regrd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;

    modport master (
        output zxuno_addr,
        output zxuno_regwr,
        output zxuno_regrd,
        output din,
        input  dout,
        input  oe
    );

    modport slave (
        input  zxuno_addr,
        input  zxuno_regwr,
        input  zxuno_regrd,
        input  din,
        output dout,
        output oe
    );

endinterface

// File: rtl/pll_option_sequencer.sv
// Owns the PLL clock-option register: captures host writes and hotkey steps, and
// presents a new pll_option only with a muted hold-off long enough for relock.
module pll_option_sequencer
    import pll_option_sequencer_pkg::*;
#(
    parameter logic [7:0]       REG_ADDR       = DEFAULT_REG_ADDR,
    parameter logic [OPT_W-1:0] DEFAULT_OPTION = 3'd0,
    parameter logic [OPT_W-1:0] MAX_OPTION     = 3'd7,
    parameter int unsigned      HOLDOFF_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    pll_option_sequencer_if.slave bus,
    input  logic                hotkey_next,
    output logic [OPT_W-1:0]    pll_option,
    output logic                busy,
    output logic                mute
);

    localparam int unsigned      CNT_W    = $clog2(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    state_e           state_q;
    logic [OPT_W-1:0] pending_q;
    logic             pend_valid_q;
    logic [CNT_W-1:0] counter_q;

    logic             write_hit;
    logic             req_valid;
    logic [OPT_W-1:0] req_option;
    logic [OPT_W-1:0] base;
    logic             unused_din;

    assign unused_din = ^bus.din[7:OPT_W];

    // A write hit, even an out-of-range one, always shadows a same-cycle hotkey.
    always_comb begin
        write_hit  = bus.zxuno_regwr && (bus.zxuno_addr == REG_ADDR);
        base       = pend_valid_q ? pending_q : pll_option;
        req_valid  = 1'b0;
        req_option = pending_q;
        if (write_hit) begin
            if (bus.din[OPT_W-1:0] <= MAX_OPTION) begin
                req_valid  = 1'b1;
                req_option = bus.din[OPT_W-1:0];
            end
        end else if (hotkey_next) begin
            req_valid  = 1'b1;
            req_option = next_option(base, MAX_OPTION);
        end
    end

    assign bus.oe = bus.zxuno_regrd && (bus.zxuno_addr == REG_ADDR);

    always_comb begin
        bus.dout = 8'h00;
        if (bus.oe) begin
            bus.dout[OPT_W-1:0]     = pll_option;
            bus.dout[DOUT_PEND_BIT] = pend_valid_q;
            bus.dout[DOUT_BUSY_BIT] = busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pll_option   <= DEFAULT_OPTION;
            pending_q    <= DEFAULT_OPTION;
            pend_valid_q <= 1'b0;
            counter_q    <= '0;
            busy         <= 1'b0;
            mute         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    counter_q <= '0;
                    // Output register loads on entry so APPLY is already visible downstream.
                    if (pend_valid_q && (pending_q != pll_option)) begin
                        state_q    <= StApply;
                        pll_option <= pending_q;
                        busy       <= 1'b1;
                        mute       <= 1'b1;
                    end
                    pend_valid_q <= 1'b0;
                end
                StApply: begin
                    counter_q <= CNT_LOAD;
                    state_q   <= StHoldoff;
                end
                StHoldoff: begin
                    if (counter_q == '0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        mute    <= 1'b0;
                    end else begin
                        counter_q <= counter_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    counter_q <= '0;
                    busy      <= 1'b0;
                    mute      <= 1'b0;
                end
            endcase
            // Placed last so a fresh request survives the IDLE clear (last-wins).
            if (req_valid) begin
                pending_q    <= req_option;
                pend_valid_q <= 1'b1;
            end
        end
    end

endmodule
